// File: rtl/uart_word_packer.sv
// Packs BYTES_PER_WORD UART byte strobes into one word and holds it on a valid/ready output.
// Optional idle-timeout flush of partial words: define UART_PACKER_TIMEOUT_EN.
module uart_word_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter bit          LSB_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  input  logic                          clear,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0] byte_count,
  output logic                          overflow,
  output logic                          overflow_seen,
  output logic                          timeout_flush
);

  localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned WW = 8 * BYTES_PER_WORD;

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_word_packer: illegal parameter value");
  end

  logic [BYTES_PER_WORD-1:0][7:0] asm_q, asm_d;
  logic [WW-1:0]                  word_data_q, word_data_d;
  logic                           word_valid_q, word_valid_d;
  logic [CW-1:0]                  byte_count_q, byte_count_d;
  logic                           overflow_q, overflow_d;
  logic                           overflow_seen_q, overflow_seen_d;
  logic [CW-1:0]                  lane;
  logic                           slot_free;
  logic                           last_byte;

`ifdef UART_PACKER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_q, idle_d;
  logic          flush_q, flush_d;
`endif

  assign lane      = LSB_FIRST ? byte_count_q : (CW'(BYTES_PER_WORD - 1) - byte_count_q);
  assign slot_free = ~word_valid_q | word_ready;
  assign last_byte = (byte_count_q == CW'(BYTES_PER_WORD - 1));

  always_comb begin
    asm_d           = asm_q;
    word_data_d     = word_data_q;
    word_valid_d    = word_valid_q;
    byte_count_d    = byte_count_q;
    overflow_d      = 1'b0;
    overflow_seen_d = overflow_seen_q;
`ifdef UART_PACKER_TIMEOUT_EN
    idle_d          = idle_q;
    flush_d         = 1'b0;
`endif
    if (clear) begin
      byte_count_d    = '0;
      word_valid_d    = 1'b0;
      overflow_seen_d = 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
      idle_d          = '0;
`endif
    end else begin
      if (word_valid_q && word_ready)
        word_valid_d = 1'b0;
      if (rx_ready) begin
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++)
          if (CW'(i) == lane) asm_d[i] = rx_data;
        if (last_byte) begin
          byte_count_d = '0;
          // The completing byte is taken from asm_d so it lands in this same load.
          if (slot_free) begin
            word_data_d  = asm_d;
            word_valid_d = 1'b1;
          end else begin
            overflow_d      = 1'b1;
            overflow_seen_d = 1'b1;
          end
        end else begin
          byte_count_d = byte_count_q + 1'b1;
        end
      end
`ifdef UART_PACKER_TIMEOUT_EN
      // A byte arriving on the expiry cycle takes precedence over the flush.
      if (rx_ready) begin
        idle_d = '0;
      end else if (byte_count_q != '0) begin
        if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
          byte_count_d = '0;
          idle_d       = '0;
          flush_d      = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end else begin
        idle_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q           <= '0;
      word_data_q     <= '0;
      word_valid_q    <= 1'b0;
      byte_count_q    <= '0;
      overflow_q      <= 1'b0;
      overflow_seen_q <= 1'b0;
    end else begin
      asm_q           <= asm_d;
      word_data_q     <= word_data_d;
      word_valid_q    <= word_valid_d;
      byte_count_q    <= byte_count_d;
      overflow_q      <= overflow_d;
      overflow_seen_q <= overflow_seen_d;
    end
  end

`ifdef UART_PACKER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      flush_q <= flush_d;
    end
  end
  assign timeout_flush = flush_q;
`else
  assign timeout_flush = 1'b0;
`endif

  assign word_data     = word_data_q;
  assign word_valid    = word_valid_q;
  assign byte_count    = byte_count_q;
  assign overflow      = overflow_q;
  assign overflow_seen = overflow_seen_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: LSB-first and MSB-first instances share one stimulus.
module tb_uart_word_packer;

  localparam int unsigned BPW = 4;
  localparam int unsigned WW  = 8 * BPW;

  logic          clk = 1'b0;
  logic          reset, rx_ready, clear, word_ready;
  logic [7:0]    rx_data;
  logic [WW-1:0] wd_l, wd_m;
  logic          wv_l, wv_m, ov_l, ov_m, os_l, os_m, tf_l, tf_m;
  logic [2:0]    bc_l, bc_m;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  uart_word_packer #(.BYTES_PER_WORD(BPW), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) u_lsb (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .clear(clear),
    .word_data(wd_l), .word_valid(wv_l), .word_ready(word_ready), .byte_count(bc_l),
    .overflow(ov_l), .overflow_seen(os_l), .timeout_flush(tf_l)
  );

  uart_word_packer #(.BYTES_PER_WORD(BPW), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) u_msb (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .clear(clear),
    .word_data(wd_m), .word_valid(wv_m), .word_ready(word_ready), .byte_count(bc_m),
    .overflow(ov_m), .overflow_seen(os_m), .timeout_flush(tf_m)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; clear = 1'b0; word_ready = 1'b0; rx_data = 8'h00;
    tick();
    chk("rst_data",  64'(wd_l), 64'h0);
    chk("rst_valid", 64'(wv_l), 64'h0);
    chk("rst_count", 64'(bc_l), 64'h0);
    chk("rst_ovf",   64'(ov_l), 64'h0);
    chk("rst_seen",  64'(os_l), 64'h0);
    chk("rst_tflush",64'(tf_l), 64'h0);
    tick();
    reset = 1'b0;
    tick();

    // 1/2: basic packing, both byte orders
    word_ready = 1'b1;
    send(8'h11); chk("msb_cnt1", 64'(bc_m), 64'd1);
    send(8'h22); chk("msb_cnt2", 64'(bc_m), 64'd2);
    send(8'h33); chk("msb_cnt3", 64'(bc_m), 64'd3);
    chk("pre_valid", 64'(wv_l), 64'h0);
    send(8'h44); chk("msb_cnt0", 64'(bc_m), 64'd0);
    chk("w1_valid", 64'(wv_l), 64'h1);
    chk("w1_lsb",   64'(wd_l), 64'h44332211);
    chk("w1_msb",   64'(wd_m), 64'h11223344);
    tick();
    chk("w1_drop",  64'(wv_l), 64'h0);

    // 3: backpressure and overflow
    word_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("bp_valid", 64'(wv_l), 64'h1);
    chk("bp_data",  64'(wd_l), 64'h04030201);
    send(8'h05); send(8'h06); send(8'h07);
    chk("bp_noovf", 64'(ov_l), 64'h0);
    send(8'h08);
    chk("ovf_pulse", 64'(ov_l), 64'h1);
    chk("ovf_seen",  64'(os_l), 64'h1);
    chk("ovf_hold",  64'(wd_l), 64'h04030201);
    chk("ovf_cnt",   64'(bc_l), 64'h0);
    tick();
    chk("ovf_end",   64'(ov_l), 64'h0);
    chk("ovf_sticky",64'(os_l), 64'h1);
    chk("ovf_stable",64'(wd_l), 64'h04030201);
    chk("ovf_vhold", 64'(wv_l), 64'h1);
    word_ready = 1'b1;
    tick();
    chk("bp_accept", 64'(wv_l), 64'h0);
    word_ready = 1'b0;

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_seen", 64'(os_l), 64'h0);
    chk("clr_valid",64'(wv_l), 64'h0);
    chk("clr_keep", 64'(wd_l), 64'h04030201);

    // 4: back-to-back acceptance and reload
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    chk("b2b_v1", 64'(wv_l), 64'h1);
    chk("b2b_d1", 64'(wd_l), 64'hA3A2A1A0);
    send(8'hB0); send(8'hB1); send(8'hB2);
    word_ready = 1'b1;
    send(8'hB3);
    chk("b2b_v2",  64'(wv_l), 64'h1);
    chk("b2b_d2",  64'(wd_l), 64'hB3B2B1B0);
    chk("b2b_ovf", 64'(ov_l), 64'h0);
    chk("b2b_seen",64'(os_l), 64'h0);
    tick();
    chk("b2b_drop", 64'(wv_l), 64'h0);

    // 5: clear beats a simultaneous byte
    send(8'hC0); send(8'hC1);
    chk("clr_pre", 64'(bc_l), 64'd2);
    rx_data = 8'hC2; rx_ready = 1'b1; clear = 1'b1;
    tick();
    rx_ready = 1'b0; clear = 1'b0;
    chk("clr_cnt", 64'(bc_l), 64'd0);
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    chk("clean_v",   64'(wv_l), 64'h1);
    chk("clean_lsb", 64'(wd_l), 64'hD3D2D1D0);
    chk("clean_msb", 64'(wd_m), 64'hD0D1D2D3);
    tick();
    chk("clean_drop", 64'(wv_l), 64'h0);

`ifdef UART_PACKER_TIMEOUT_EN
    // 6: idle timeout with TIMEOUT_CYCLES=16
    send(8'hE0);
    chk("to_cnt1", 64'(bc_l), 64'd1);
    repeat (15) tick();
    chk("to_early_f", 64'(tf_l), 64'h0);
    chk("to_early_c", 64'(bc_l), 64'd1);
    tick();
    chk("to_flush", 64'(tf_l), 64'h1);
    chk("to_cnt0",  64'(bc_l), 64'd0);
    chk("to_valid", 64'(wv_l), 64'h0);
    tick();
    chk("to_pulse_end", 64'(tf_l), 64'h0);
    send(8'hE1);
    repeat (15) tick();
    send(8'hE2);
    chk("to_win_f", 64'(tf_l), 64'h0);
    chk("to_win_c", 64'(bc_l), 64'd2);
    tick();
    chk("to_after_f", 64'(tf_l), 64'h0);
    chk("to_after_c", 64'(bc_l), 64'd2);
`endif

    // reset mid-word with a held output word
    clear = 1'b1; tick(); clear = 1'b0;
    word_ready = 1'b0;
    send(8'hF0); send(8'hF1); send(8'hF2); send(8'hF3);
    send(8'hF4);
    chk("mid_valid", 64'(wv_l), 64'h1);
    chk("mid_cnt",   64'(bc_l), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_data",  64'(wd_l), 64'h0);
    chk("arst_valid", 64'(wv_l), 64'h0);
    chk("arst_cnt",   64'(bc_l), 64'h0);
    chk("arst_ovf",   64'(ov_l), 64'h0);
    chk("arst_tf",    64'(tf_l), 64'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
